sum_window_stats: RTL and testbench

Downstream consumer of the running-sum adder stage. Takes the adder's 11-bit sum stream, groups it into fixed windows of 2^LOG2_WIN accepted samples, and emits one result per window: truncated average, minimum, maximum and a sequence number. The result leaves through a one-deep valid/ready output register so a slow sink (logger, UART packer) can apply backpressure without stalling the adder.

---
 rtl/sum_stats_pkg.sv | 23 ++
 rtl/minmax_tracker.sv | 58 +++++
 rtl/sum_window_stats.sv | 149 ++++++++++++++
 tb/tb_sum_window_stats.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sum_stats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_stats_pkg
//  Description : Shared constants and the output-register state encoding
//                for the windowed sum statistics block.
//  Revision    : 1.0  initial release
// ============================================================================
package sum_stats_pkg;

    // Default width of the incoming running-sum samples
    localparam int unsigned IN_W_DEFAULT = 11;

    // Width of the window sequence number (wraps 255 -> 0)
    localparam int unsigned SEQ_W = 8;

    // Output register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage : sum_stats_pkg
`default_nettype wire

// File: rtl/minmax_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : minmax_tracker
//  Description : Tracks unsigned minimum and maximum of a sample stream.
//                i_load restarts tracking from the current sample,
//                i_update folds the current sample into the running values.
//                o_*_nxt expose the values including the current sample so
//                the caller can capture them on the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module minmax_tracker #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_update,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_min,
    output logic [WIDTH-1:0] o_max,
    output logic [WIDTH-1:0] o_min_nxt,
    output logic [WIDTH-1:0] o_max_nxt
);

    logic [WIDTH-1:0] min_d, min_q;
    logic [WIDTH-1:0] max_d, max_q;

    // Next min/max: load overrides update so a new window never sees stale values
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (i_load) begin
            min_d = i_data;
            max_d = i_data;
        end else if (i_update) begin
            if (i_data < min_q) min_d = i_data;
            if (i_data > max_q) max_d = i_data;
        end
    end

    // Min/max state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign o_min     = min_q;
    assign o_max     = max_q;
    assign o_min_nxt = min_d;
    assign o_max_nxt = max_d;

endmodule : minmax_tracker
`default_nettype wire

// File: rtl/sum_window_stats.sv
`default_nettype none
// ============================================================================
//  Module      : sum_window_stats
//  Description : Groups an unsigned sample stream into windows of
//                2^LOG2_WIN accepted samples and emits average, min, max
//                and sequence number per window through a one-deep
//                valid/ready result register with sticky overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
module sum_window_stats
    import sum_stats_pkg::*;
#(
    parameter int unsigned IN_W     = IN_W_DEFAULT,
    parameter int unsigned LOG2_WIN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IN_W-1:0]  out_avg,
    output logic [IN_W-1:0]  out_min,
    output logic [IN_W-1:0]  out_max,
    output logic [SEQ_W-1:0] out_seq,
    output logic             overrun
);

    // Accumulator is wide enough to hold a full window of max-valued samples
    localparam int unsigned c_ACC_W = IN_W + LOG2_WIN;

    logic [c_ACC_W-1:0]  acc_d, acc_q;
    logic [LOG2_WIN-1:0] cnt_d, cnt_q;
    logic [SEQ_W-1:0]    win_d, win_q;
    out_state_e          state_d, state_q;
    logic [IN_W-1:0]     avg_d, avg_q;
    logic [IN_W-1:0]     rmin_d, rmin_q;
    logic [IN_W-1:0]     rmax_d, rmax_q;
    logic [SEQ_W-1:0]    seq_d, seq_q;
    logic                overrun_d, overrun_q;

    logic                w_first;
    logic                w_complete;
    logic [c_ACC_W-1:0]  w_acc_sum;
    logic [IN_W-1:0]     w_min_cur, w_max_cur;
    logic [IN_W-1:0]     w_min_nxt, w_max_nxt;

    assign w_first    = (cnt_q == '0);
    assign w_complete = in_valid && (cnt_q == {LOG2_WIN{1'b1}});
    // First sample of a window starts from zero rather than the old total
    assign w_acc_sum  = (w_first ? '0 : acc_q) + c_ACC_W'(in_data);

    minmax_tracker #(
        .WIDTH (IN_W)
    ) u_minmax (
        .clk       (clk),
        .reset     (reset),
        .i_load    (in_valid && w_first),
        .i_update  (in_valid && !w_first),
        .i_data    (in_data),
        .o_min     (w_min_cur),
        .o_max     (w_max_cur),
        .o_min_nxt (w_min_nxt),
        .o_max_nxt (w_max_nxt)
    );

    // Window accumulation: sum, sample count and window index
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        win_d = win_q;
        if (in_valid) begin
            acc_d = w_acc_sum;
            cnt_d = cnt_q + 1'b1;
        end
        if (w_complete) begin
            win_d = win_q + 1'b1;
        end
    end

    // Result register and occupancy FSM; a completion always loads new fields
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        avg_d     = avg_q;
        rmin_d    = rmin_q;
        rmax_d    = rmax_q;
        seq_d     = seq_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_complete) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (w_complete) begin
                    state_d = ST_FULL;
                    // Overwriting a result the sink never took
                    if (!out_ready) overrun_d = 1'b1;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (w_complete) begin
            avg_d  = w_acc_sum[c_ACC_W-1 -: IN_W];
            rmin_d = w_min_nxt;
            rmax_d = w_max_nxt;
            seq_d  = win_q;
        end
    end

    // All state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            win_q     <= '0;
            state_q   <= ST_EMPTY;
            avg_q     <= '0;
            rmin_q    <= '0;
            rmax_q    <= '0;
            seq_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            state_q   <= state_d;
            avg_q     <= avg_d;
            rmin_q    <= rmin_d;
            rmax_q    <= rmax_d;
            seq_q     <= seq_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_avg   = avg_q;
    assign out_min   = rmin_q;
    assign out_max   = rmax_q;
    assign out_seq   = seq_q;
    assign overrun   = overrun_q;

    // Running min/max registers are only observed through the result path
    logic w_unused;
    assign w_unused = ^{w_min_cur, w_max_cur};

endmodule : sum_window_stats
`default_nettype wire

// File: tb/tb_sum_window_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_window_stats
//  Description : Scoreboard bench for sum_window_stats with LOG2_WIN=2.
//                Stimulus pushes hand-computed results; a monitor pops and
//                compares on every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_window_stats;

    localparam int IN_W     = 11;
    localparam int LOG2_WIN = 2;

    typedef struct {
        int avg;
        int mn;
        int mx;
        int seq;
    } result_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [IN_W-1:0] out_avg;
    logic [IN_W-1:0] out_min;
    logic [IN_W-1:0] out_max;
    logic [7:0]      out_seq;
    logic            overrun;

    int      n_tests = 0;
    int      n_fail  = 0;
    result_t exp_q[$];

    always #5 clk = ~clk;

    sum_window_stats #(
        .IN_W     (IN_W),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_avg   (out_avg),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_seq   (out_seq),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the edge
    task automatic step(input logic v, input int d);
        in_valid = v;
        in_data  = IN_W'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        reset = 1'b1;
        step(v, 500);
        reset = 1'b0;
    endtask

    task automatic push(input int a, input int mn, input int mx, input int s);
        result_t r;
        r.avg = a; r.mn = mn; r.mx = mx; r.seq = s;
        exp_q.push_back(r);
    endtask

    // Monitor: sample between edges, compare on each accepted result
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_seq", int'(out_seq), -1);
                end else begin
                    result_t r;
                    r = exp_q.pop_front();
                    chk("avg", int'(out_avg), r.avg);
                    chk("min", int'(out_min), r.mn);
                    chk("max", int'(out_max), r.mx);
                    chk("seq", int'(out_seq), r.seq);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        do_reset(1'b0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_avg", int'(out_avg), 0);
        chk("rst_min", int'(out_min), 0);
        chk("rst_max", int'(out_max), 0);
        chk("rst_seq", int'(out_seq), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Basic window 1,2,3,4 and one-cycle latency
        push(2, 1, 4, 0);
        step(1, 1); step(1, 2); step(1, 3);
        chk("lat_before", int'(out_valid), 0);
        step(1, 4);
        chk("lat_after", int'(out_valid), 1);
        step(0, 0);
        chk("drained", int'(out_valid), 0);

        // Full-scale samples then zeros, back to back
        do_reset(1'b0);
        push(2047, 2047, 2047, 0);
        push(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 2047);
        for (int i = 0; i < 4; i++) step(1, 0);
        step(0, 0);
        chk("full_overrun", int'(overrun), 0);

        // Gaps inside a window: 5,_,_,9,_,1,3
        do_reset(1'b0);
        push(4, 1, 9, 0);
        step(1, 5); step(0, 77); step(0, 77); step(1, 9);
        step(0, 77); step(1, 1); step(1, 3);
        step(0, 0);

        // Backpressure: two windows with no sink, second overwrites first
        do_reset(1'b0);
        out_ready = 1'b0;
        push(6, 5, 8, 1);
        for (int i = 1; i <= 4; i++) step(1, i);
        chk("ovr_after_first", int'(overrun), 0);
        for (int i = 5; i <= 8; i++) step(1, i);
        chk("ovr_valid_held", int'(out_valid), 1);
        chk("ovr_set", int'(overrun), 1);
        out_ready = 1'b1;
        step(0, 0);
        chk("ovr_drop_valid", int'(out_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);

        // Handshake on the same edge as a completion
        do_reset(1'b0);
        out_ready = 1'b0;
        push(25, 10, 40, 0);
        push(1, 1, 1, 1);
        step(1, 10); step(1, 20); step(1, 30); step(1, 40);
        step(1, 1); step(1, 1); step(1, 1);
        out_ready = 1'b1;
        step(1, 1);
        chk("coinc_valid", int'(out_valid), 1);
        chk("coinc_overrun", int'(overrun), 0);
        step(0, 0);
        chk("coinc_drained", int'(out_valid), 0);

        // Reset mid-window (with a sample alongside reset), then clean window
        do_reset(1'b0);
        step(1, 7); step(1, 8); step(1, 9);
        do_reset(1'b1);
        push(10, 10, 10, 0);
        for (int i = 0; i < 4; i++) step(1, 10);
        chk("rstmid_overrun", int'(overrun), 0);
        step(0, 0);

        step(0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sum_window_stats
`default_nettype wire
